melody_player: RTL and testbench



---
 rtl/melody_player.sv | 117 +++++++++++
 tb/tb_melody_player.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Melody sequencer: steps through an external synchronous note ROM and drives
// a square-wave buzzer, advancing one ROM step every NOTE_TICKS + 2 clocks.
module melody_player #(
    parameter int NOTE_TICKS = 12500000,
    parameter int TONE_SCALE = 1000,
    parameter int LAST_ADDR  = 31,
    parameter int LOOP       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] note,
    output logic [4:0] rom_addr,
    output logic       buzzer,
    output logic       playing,
    output logic       done
);

    localparam int HP_W  = 8 + $clog2(TONE_SCALE + 1);
    localparam int DUR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

    state_t             state;
    logic               armed;
    logic [7:0]         note_r;
    logic [HP_W-1:0]    half_per;
    logic [HP_W-1:0]    tone_cnt;
    logic [DUR_W-1:0]   dur_cnt;
    logic               last_tick;

    assign last_tick = (dur_cnt == DUR_W'(NOTE_TICKS - 1));

    // armed blocks a retrigger after a single pass until en has been seen low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b1;
            note_r   <= '0;
            half_per <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            rom_addr <= '0;
            buzzer   <= 1'b0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!en) begin
                armed <= 1'b1;
            end
            if (state == IDLE) begin
                buzzer <= 1'b0;
                if (en && armed) begin
                    rom_addr <= '0;
                    playing  <= 1'b1;
                    state    <= FETCH;
                end
            end else if (!en) begin
                state    <= IDLE;
                buzzer   <= 1'b0;
                rom_addr <= '0;
                playing  <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        note_r   <= note;
                        half_per <= HP_W'(note) * HP_W'(TONE_SCALE);
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        buzzer   <= 1'b0;
                        state    <= PLAY;
                    end
                    PLAY: begin
                        if (note_r != 8'd0) begin
                            if (tone_cnt == half_per - HP_W'(1)) begin
                                tone_cnt <= '0;
                                buzzer   <= ~buzzer;
                            end else begin
                                tone_cnt <= tone_cnt + HP_W'(1);
                            end
                        end else begin
                            buzzer <= 1'b0;
                        end
                        // Later assignments in the step-end branch override the tone toggle
                        if (last_tick) begin
                            dur_cnt <= '0;
                            if (rom_addr < 5'(LAST_ADDR)) begin
                                rom_addr <= rom_addr + 5'd1;
                                state    <= FETCH;
                            end else if (LOOP != 0) begin
                                rom_addr <= '0;
                                state    <= FETCH;
                            end else begin
                                done     <= 1'b1;
                                armed    <= 1'b0;
                                buzzer   <= 1'b0;
                                rom_addr <= '0;
                                playing  <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench for melody_player: one looping and one single-pass
// instance, each fed by its own registered ROM model.
module tb_melody_player;

    localparam int TICKS = 8;
    localparam int NSTEP = 4;

    typedef struct {
        logic [4:0] addr;
        logic       chk_addr;
        logic       buzz;
        logic       playing;
        logic       done;
    } exp_t;

    typedef struct {
        logic en;
        exp_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_loop, en_once;
    logic [7:0] note_loop, note_once;
    logic [4:0] addr_loop, addr_once;
    logic       buzz_loop, buzz_once;
    logic       play_loop, play_once;
    logic       done_loop, done_once;

    logic [7:0] rom [32];
    exp_t       sb[$];
    vec_t       loop_vecs[65];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        note_loop <= rom[addr_loop];
        note_once <= rom[addr_once];
    end

    melody_player #(.NOTE_TICKS(TICKS), .TONE_SCALE(1), .LAST_ADDR(3), .LOOP(1)) dut_loop (
        .clk(clk), .rst_n(rst_n), .en(en_loop), .note(note_loop),
        .rom_addr(addr_loop), .buzzer(buzz_loop), .playing(play_loop), .done(done_loop)
    );

    melody_player #(.NOTE_TICKS(TICKS), .TONE_SCALE(1), .LAST_ADDR(3), .LOOP(0)) dut_once (
        .clk(clk), .rst_n(rst_n), .en(en_once), .note(note_once),
        .rom_addr(addr_once), .buzzer(buzz_once), .playing(play_once), .done(done_once)
    );

    function automatic exp_t mk(input int a, input bit chk, input bit b, input bit p, input bit d);
        exp_t e;
        e.addr     = 5'(a);
        e.chk_addr = chk;
        e.buzz     = b;
        e.playing  = p;
        e.done     = d;
        return e;
    endfunction

    // Expected outputs n edges after en is first sampled high, from the step timeline
    function automatic exp_t model_play(input int n);
        exp_t e;
        int m, step, ph, a, nt, prev;
        m    = n - 1;
        step = m / (TICKS + 2);
        ph   = m % (TICKS + 2);
        a    = step % NSTEP;
        e    = mk(a, 1'b1, 1'b0, 1'b1, 1'b0);
        if (ph >= 2) begin
            nt = int'(rom[a]);
            e.buzz = (nt != 0) && ((((ph - 2) / nt) % 2) != 0);
        end else if (step > 0) begin
            prev = int'(rom[(a + NSTEP - 1) % NSTEP]);
            e.buzz = (prev != 0) && (((TICKS / prev) % 2) != 0);
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit sel, input logic en_v, input exp_t e);
        if (sel) en_once = en_v;
        else     en_loop = en_v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input bit sel);
        exp_t e;
        logic [4:0] a;
        logic b, p, d;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, no expected record", name);
            return;
        end
        e = sb.pop_front();
        a = sel ? addr_once : addr_loop;
        b = sel ? buzz_once : buzz_loop;
        p = sel ? play_once : play_loop;
        d = sel ? done_once : done_loop;
        if (b !== e.buzz || p !== e.playing || d !== e.done || (e.chk_addr && a !== e.addr)) begin
            n_fail++;
            $display("[TB] FAIL %s: got addr=%0d buzzer=%b playing=%b done=%b, expected addr=%0d(chk=%b) buzzer=%b playing=%b done=%b",
                     name, a, b, p, d, e.addr, e.chk_addr, e.buzz, e.playing, e.done);
        end
    endtask

    task automatic runCycle(input string name, input bit sel, input logic en_v, input exp_t e);
        applyStimulus(sel, en_v, e);
        @(posedge clk);
        #1;
        checkOutput(name, sel);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'd0;
        rom[0] = 8'd5;
        rom[1] = 8'd0;
        rom[2] = 8'd2;
        rom[3] = 8'd3;
        for (int i = 0; i < 65; i++) begin
            loop_vecs[i].en  = 1'b1;
            loop_vecs[i].exp = model_play(i + 1);
        end

        rst_n   = 1'b0;
        en_loop = 1'b0;
        en_once = 1'b0;
        #12;
        applyStimulus(0, 1'b0, mk(0, 1, 0, 0, 0));
        checkOutput("reset loop", 0);
        applyStimulus(1, 1'b0, mk(0, 1, 0, 0, 0));
        checkOutput("reset once", 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runCycle("idle loop", 0, 1'b0, mk(0, 1, 0, 0, 0));

        // Single pass: four steps, done pulse, then held off while en stays high
        for (int n = 1; n <= 40; n++)
            runCycle($sformatf("once n=%0d", n), 1, 1'b1, model_play(n));
        runCycle("once finish", 1, 1'b1, mk(0, 0, 0, 0, 1));
        for (int n = 0; n < 5; n++)
            runCycle($sformatf("once hold %0d", n), 1, 1'b1, mk(0, 0, 0, 0, 0));
        runCycle("once rearm", 1, 1'b0, mk(0, 0, 0, 0, 0));
        for (int n = 1; n <= 3; n++)
            runCycle($sformatf("once restart n=%0d", n), 1, 1'b1, model_play(n));
        runCycle("once stop", 1, 1'b0, mk(0, 1, 0, 0, 0));

        // Looping playback: start, rest, wrap past LAST_ADDR, into addr2 with buzzer high
        for (int i = 0; i < 65; i++)
            runCycle($sformatf("loop n=%0d", i + 1), 0, loop_vecs[i].en, loop_vecs[i].exp);
        runCycle("abort", 0, 1'b0, mk(0, 1, 0, 0, 0));
        runCycle("abort idle", 0, 1'b0, mk(0, 1, 0, 0, 0));
        for (int n = 1; n <= 8; n++)
            runCycle($sformatf("restart n=%0d", n), 0, 1'b1, model_play(n));

        // Asynchronous reset between edges while the buzzer is high
        #2;
        rst_n = 1'b0;
        #1;
        applyStimulus(0, 1'b1, mk(0, 1, 0, 0, 0));
        checkOutput("async reset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 11; n++)
            runCycle($sformatf("post reset n=%0d", n), 0, 1'b1, model_play(n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
